// File: rtl/z80_interrupt_controller.sv
// Z80 IM2 vectored interrupt controller: fixed-priority merge of NUM_IRQ requests, IM2 vector on ack, in-service nesting until EOI.
// Latency: o_int_n falls one clock after an eligible pending request (level PEND samples i_irq one clock earlier); read/vector data is combinational.
// Backpressure: none; a request is held in REQ until the CPU acks. Z80_INTC_EDGE_EN selects edge-captured PEND (default level mode).
module z80_interrupt_controller #(
    parameter int NUM_IRQ = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cs_n,
    input  logic               i_wr_n,
    input  logic               i_rd_n,
    input  logic [1:0]         i_addr,
    input  logic [7:0]         i_data,
    output logic [7:0]         o_data,
    output logic               o_data_en,
    input  logic               i_m1_n,
    input  logic               i_iorq_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic               o_int_n
);

    localparam logic [7:0] VALID = 8'((16'd1 << NUM_IRQ) - 16'd1);

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t     state_q, state_d;
    logic [3:0] vbase_q;
    logic [7:0] mask_q, pend_q, isr_q;
    logic [2:0] req_w_q, req_w_d;
    logic [7:0] vec_q, vec_d;
    logic       wr_prev_q, int_n_q;
    logic [7:0] irq8, req, isr_set, eoi_bit, rd_dat;
    logic [2:0] w;
    logic       has_req, blocked, eligible;
    logic       wr_act, wr_fire, rd_act, ack_cyc;
    logic       wr_vbase, wr_mask, wr_eoi;

    assign irq8     = 8'(i_irq) & VALID;
    assign wr_act   = !i_cs_n && !i_wr_n;
    assign wr_fire  = wr_act && !wr_prev_q;
    assign rd_act   = !i_cs_n && !i_rd_n;
    assign ack_cyc  = !i_m1_n && !i_iorq_n;
    assign wr_vbase = wr_fire && (i_addr == 2'd0);
    assign wr_mask  = wr_fire && (i_addr == 2'd1);
    assign wr_eoi   = wr_fire && (i_addr == 2'd3);
    assign eoi_bit  = wr_eoi ? (isr_q & (~isr_q + 8'd1)) : 8'd0;

    // Winner is the lowest enabled pending index; blocked by any in-service level at or above it.
    always_comb begin
        req     = pend_q & mask_q;
        w       = 3'd0;
        has_req = 1'b0;
        blocked = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                w       = 3'(i);
                has_req = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if ((i <= int'(w)) && isr_q[i]) blocked = 1'b1;
        end
        eligible = has_req && !blocked;
    end

    always_comb begin
        state_d = state_q;
        req_w_d = req_w_q;
        vec_d   = vec_q;
        isr_set = 8'd0;
        case (state_q)
            IDLE: begin
                if (ack_cyc) begin
                    state_d = ACK;
                    vec_d   = {vbase_q, 3'b111, 1'b0};
                end else if (eligible) begin
                    state_d = REQ;
                    req_w_d = w;
                end
            end
            REQ: begin
                // The ack commits the frozen winner even if it is masked in this same clock.
                if (ack_cyc) begin
                    state_d = ACK;
                    vec_d   = {vbase_q, req_w_q, 1'b0};
                    isr_set = 8'd1 << req_w_q;
                end else if (!eligible || (w != req_w_q)) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (i_iorq_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            req_w_q   <= 3'd0;
            vec_q     <= 8'd0;
            vbase_q   <= 4'd0;
            mask_q    <= 8'd0;
            isr_q     <= 8'd0;
            wr_prev_q <= 1'b0;
            int_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            req_w_q   <= req_w_d;
            vec_q     <= vec_d;
            wr_prev_q <= wr_act;
            int_n_q   <= (state_d != REQ);
            if (wr_vbase) vbase_q <= i_data[7:4];
            if (wr_mask)  mask_q  <= i_data & VALID;
            isr_q <= ((isr_q & ~eoi_bit) | isr_set) & VALID;
        end
    end

`ifdef Z80_INTC_EDGE_EN
    logic [7:0] irq_prev_q;
    logic       wr_pend;
    assign wr_pend = wr_fire && (i_addr == 2'd2);

    // Rising edges set PEND; ack entry or a write-one to reg 2 clears it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            irq_prev_q <= 8'd0;
            pend_q     <= 8'd0;
        end else begin
            irq_prev_q <= irq8;
            pend_q     <= (pend_q & ~(isr_set | (wr_pend ? (i_data & VALID) : 8'd0)))
                        | (irq8 & ~irq_prev_q);
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) pend_q <= 8'd0;
        else         pend_q <= irq8;
    end
`endif

    always_comb begin
        case (i_addr)
            2'd0:    rd_dat = {vbase_q, 4'h0};
            2'd1:    rd_dat = mask_q;
            2'd2:    rd_dat = pend_q;
            default: rd_dat = isr_q;
        endcase
    end

    assign o_data_en = !i_reset && ((state_q == ACK) || rd_act);
    assign o_data    = i_reset            ? 8'd0  :
                       (state_q == ACK)   ? vec_q :
                       rd_act             ? rd_dat : 8'd0;
    assign o_int_n   = int_n_q;

endmodule

// File: tb/tb_z80_interrupt_controller.sv
// Bench for z80_interrupt_controller: vector table through a scoreboard queue, plus an async-reset-mid-ACK sequence.
module tb_z80_interrupt_controller;

    typedef struct {
        logic       cs_n, wr_n, rd_n;
        logic [1:0] addr;
        logic [7:0] wdat;
        logic       m1_n, iorq_n;
        logic [3:0] irq;
        logic       e_int_n, e_den;
        logic [7:0] e_dat;
    } vec_t;

    logic       i_clk = 1'b0, i_reset = 1'b1;
    logic       i_cs_n = 1'b1, i_wr_n = 1'b1, i_rd_n = 1'b1;
    logic [1:0] i_addr = 2'd0;
    logic [7:0] i_data = 8'd0;
    logic       i_m1_n = 1'b1, i_iorq_n = 1'b1;
    logic [3:0] i_irq = 4'd0;
    logic [7:0] o_data;
    logic       o_data_en, o_int_n;

    int   n_vec = 0, n_err = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    z80_interrupt_controller #(.NUM_IRQ(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cs_n(i_cs_n), .i_wr_n(i_wr_n), .i_rd_n(i_rd_n),
        .i_addr(i_addr), .i_data(i_data), .o_data(o_data), .o_data_en(o_data_en),
        .i_m1_n(i_m1_n), .i_iorq_n(i_iorq_n), .i_irq(i_irq), .o_int_n(o_int_n)
    );

    always #5 i_clk = ~i_clk;

    function automatic vec_t mk(logic cs, logic wr, logic rd, logic [1:0] a, logic [7:0] d,
                                logic m1, logic io, logic [3:0] irq,
                                logic ei, logic ed, logic [7:0] edat);
        vec_t v;
        v.cs_n = cs; v.wr_n = wr; v.rd_n = rd; v.addr = a; v.wdat = d;
        v.m1_n = m1; v.iorq_n = io; v.irq = irq;
        v.e_int_n = ei; v.e_den = ed; v.e_dat = edat;
        return v;
    endfunction

    function automatic vec_t v_idle(logic [3:0] irq, logic ei);
        return mk(1, 1, 1, 2'd0, 8'h00, 1, 1, irq, ei, 0, 8'h00);
    endfunction
    function automatic vec_t v_wr(logic [1:0] a, logic [7:0] d, logic [3:0] irq);
        return mk(0, 0, 1, a, d, 1, 1, irq, 1, 0, 8'h00);
    endfunction
    function automatic vec_t v_rd(logic [1:0] a, logic [3:0] irq, logic [7:0] edat);
        return mk(0, 1, 0, a, 8'h00, 1, 1, irq, 1, 1, edat);
    endfunction
    function automatic vec_t v_ack(logic [3:0] irq, logic [7:0] edat);
        return mk(1, 1, 1, 2'd0, 8'h00, 0, 0, irq, 1, 1, edat);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, want);
        end
    endtask

    task automatic drive_idle();
        i_cs_n = 1; i_wr_n = 1; i_rd_n = 1; i_addr = 2'd0; i_data = 8'h00;
        i_m1_n = 1; i_iorq_n = 1; i_irq = 4'd0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge i_clk);
        i_cs_n = v.cs_n; i_wr_n = v.wr_n; i_rd_n = v.rd_n; i_addr = v.addr; i_data = v.wdat;
        i_m1_n = v.m1_n; i_iorq_n = v.iorq_n; i_irq = v.irq;
        exp_q.push_back(v);
        @(posedge i_clk);
        #1;
        e = exp_q.pop_front();
        chk("int_n",   idx, {7'd0, o_int_n},   {7'd0, e.e_int_n});
        chk("data_en", idx, {7'd0, o_data_en}, {7'd0, e.e_den});
        chk("data",    idx, o_data,            e.e_dat);
    endtask

    initial begin
`ifdef Z80_INTC_EDGE_EN
        tbl.push_back(v_wr(2'd0, 8'h40, 4'b0000));
        tbl.push_back(v_idle(4'b0000, 1));
        tbl.push_back(v_idle(4'b0100, 1));          // single-clock pulse on irq2
        tbl.push_back(v_idle(4'b0000, 1));
        tbl.push_back(v_rd(2'd2, 4'b0000, 8'h04));  // pulse captured and held
        tbl.push_back(v_wr(2'd2, 8'h04, 4'b0000));
        tbl.push_back(v_rd(2'd2, 4'b0000, 8'h00));
        tbl.push_back(v_idle(4'b0100, 1));
        tbl.push_back(v_wr(2'd1, 8'h0F, 4'b0000));
        tbl.push_back(v_idle(4'b0000, 0));
        tbl.push_back(v_ack(4'b0000, 8'h44));
        tbl.push_back(v_idle(4'b0000, 1));
        tbl.push_back(v_rd(2'd2, 4'b0000, 8'h00));  // ack cleared pending
        tbl.push_back(v_rd(2'd3, 4'b0000, 8'h04));
`else
        tbl.push_back(v_wr(2'd1, 8'h01, 4'b0000));
        tbl.push_back(v_idle(4'b0000, 1));
        tbl.push_back(v_wr(2'd0, 8'h40, 4'b0000));
        tbl.push_back(v_idle(4'b0001, 1));
        tbl.push_back(v_idle(4'b0001, 0));
        tbl.push_back(v_ack(4'b0001, 8'h40));
        tbl.push_back(v_ack(4'b0001, 8'h40));
        tbl.push_back(v_idle(4'b0001, 1));
        tbl.push_back(v_rd(2'd3, 4'b0001, 8'h01));
        tbl.push_back(v_idle(4'b0000, 1));
        tbl.push_back(v_wr(2'd3, 8'h00, 4'b0000));
        tbl.push_back(v_idle(4'b0000, 1));
        tbl.push_back(v_wr(2'd1, 8'h0F, 4'b0110));
        tbl.push_back(v_idle(4'b0110, 0));
        tbl.push_back(v_ack(4'b0110, 8'h42));
        tbl.push_back(v_idle(4'b0110, 1));
        tbl.push_back(v_idle(4'b0110, 1));          // index 2 held off by ISR[1]
        tbl.push_back(v_rd(2'd3, 4'b0110, 8'h02));
        tbl.push_back(v_idle(4'b0100, 1));
        tbl.push_back(v_idle(4'b0100, 1));
        tbl.push_back(v_wr(2'd3, 8'h00, 4'b0100));
        tbl.push_back(v_idle(4'b0100, 0));
        tbl.push_back(v_ack(4'b0100, 8'h44));
        tbl.push_back(v_idle(4'b0100, 1));
        tbl.push_back(v_idle(4'b0101, 1));
        tbl.push_back(v_idle(4'b0101, 0));          // nesting above ISR[2]
        tbl.push_back(v_ack(4'b0101, 8'h40));
        tbl.push_back(v_idle(4'b0100, 1));
        tbl.push_back(v_wr(2'd3, 8'h00, 4'b0100));
        tbl.push_back(v_idle(4'b1000, 1));
        tbl.push_back(v_idle(4'b1000, 1));          // lower priority stays held off
        tbl.push_back(v_rd(2'd3, 4'b1000, 8'h04));
        tbl.push_back(v_wr(2'd3, 8'h00, 4'b1000));
        tbl.push_back(v_idle(4'b1000, 0));
        tbl.push_back(v_idle(4'b0000, 0));
        tbl.push_back(v_idle(4'b0000, 1));          // request withdrawn before ack
        tbl.push_back(v_ack(4'b0000, 8'h4E));       // spurious vector
        tbl.push_back(v_idle(4'b0000, 1));
        tbl.push_back(v_rd(2'd3, 4'b0000, 8'h00));
        tbl.push_back(v_rd(2'd1, 4'b0000, 8'h0F));
        tbl.push_back(v_rd(2'd0, 4'b0000, 8'h40));
        tbl.push_back(v_rd(2'd2, 4'b0000, 8'h00));
        tbl.push_back(v_idle(4'b0010, 1));
        tbl.push_back(v_idle(4'b0010, 0));
        tbl.push_back(mk(0, 0, 1, 2'd1, 8'h00, 0, 0, 4'b0010, 1, 1, 8'h42)); // MASK write races ack
        tbl.push_back(v_idle(4'b0000, 1));
        tbl.push_back(v_rd(2'd1, 4'b0000, 8'h00));
`endif

        drive_idle();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_int_n",   -1, {7'd0, o_int_n},   8'h01);
        chk("rst_data_en", -1, {7'd0, o_data_en}, 8'h00);
        chk("rst_data",    -1, o_data,            8'h00);
        @(negedge i_clk);
        i_reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        apply(v_wr(2'd1, 8'h0F, 4'b0000), 100);
        apply(v_idle(4'b0001, 1), 101);
        apply(v_idle(4'b0001, 0), 102);
        apply(v_ack(4'b0001, 8'h40), 103);
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_int_n",   104, {7'd0, o_int_n},   8'h01);
        chk("arst_data_en", 104, {7'd0, o_data_en}, 8'h00);
        chk("arst_data",    104, o_data,            8'h00);
        drive_idle();
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        apply(v_rd(2'd1, 4'b0000, 8'h00), 105);
        apply(v_rd(2'd3, 4'b0000, 8'h00), 106);
        apply(v_rd(2'd0, 4'b0000, 8'h00), 107);
        apply(v_idle(4'b0000, 1), 108);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
